gzip_seq_unit: RTL and testbench

//  Multi-cycle generalized zip/unzip (gzip) engine with valid/ready handshakes on both sides.

---
 rtl/gzip_seq_unit.sv | 117 +++++++++++
 tb/tb_gzip_seq_unit.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/gzip_seq_unit.sv
// gzip_seq_unit: multi-cycle generalized zip/unzip, one butterfly stage per clock.
// Optional build macro GZIP_SEQ_SKIP_EN: RUN visits only the enabled stages.
module gzip_seq_unit #(
  parameter int TAG_W = 4
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_rd,
  output logic [TAG_W-1:0] out_tag
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [31:0]      work_q, work_d;
  logic [4:0]       rs2_q, rs2_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [31:0]      rd_q, rd_d;
  logic [TAG_W-1:0] otag_q, otag_d;
  logic [3:0]       en;
  logic [31:0]      stepped;
  logic [2:0]       nxt, init;

  // Stage enables listed in visiting order (position 0 is visited first).
  function automatic logic [3:0] en_of(input logic [4:0] r);
    en_of = r[0] ? {r[1], r[2], r[3], r[4]} : r[4:1];
  endfunction

  // One butterfly stage; s selects N = 1 << s.
  function automatic logic [31:0] stage(input logic [31:0] x, input logic [1:0] s);
    logic [31:0] l, r;
    l = s == 2'd3 ? 32'h00ff0000 : s == 2'd2 ? 32'h0f000f00 : s == 2'd1 ? 32'h30303030 : 32'h44444444;
    r = s == 2'd3 ? 32'h0000ff00 : s == 2'd2 ? 32'h00f000f0 : s == 2'd1 ? 32'h0c0c0c0c : 32'h22222222;
    stage = (x & ~(l | r)) | ((x << (6'd1 << s)) & l) | ((x >> (6'd1 << s)) & r);
  endfunction

`ifdef GZIP_SEQ_SKIP_EN
  // First enabled position at or after 'from'; 4 when none remains.
  function automatic logic [2:0] seek(input logic [3:0] e, input logic [2:0] from);
    seek = 3'd4;
    for (int p = 3; p >= 0; p--)
      if (p >= int'(from) && e[p]) seek = 3'(p);
  endfunction
  logic [2:0] first;
  assign first = seek(en_of(in_rs2), 3'd0);
  assign init  = first == 3'd4 ? 3'd0 : first;
  assign nxt   = seek(en, cnt_q + 3'd1);
`else
  assign init  = 3'd0;
  assign nxt   = cnt_q + 3'd1;
`endif

  assign en        = en_of(rs2_q);
  assign stepped   = en[cnt_q[1:0]] ? stage(work_q, rs2_q[0] ? ~cnt_q[1:0] : cnt_q[1:0]) : work_q;
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign out_rd    = rd_q;
  assign out_tag   = otag_q;

  // Next-state: accept in IDLE, one stage per RUN cycle, wait for consumer in DONE.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    rs2_d   = rs2_q;
    tag_d   = tag_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    otag_d  = otag_q;
    if (state_q == IDLE && in_valid) begin
      state_d = RUN;
      work_d  = in_rs1;
      rs2_d   = in_rs2;
      tag_d   = in_tag;
      cnt_d   = init;
    end else if (state_q == RUN) begin
      work_d = stepped;
      cnt_d  = nxt;
      if (nxt == 3'd4) begin
        state_d = DONE;
        rd_d    = stepped;
        otag_d  = tag_q;
      end
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      work_q  <= '0;
      rs2_q   <= '0;
      tag_q   <= '0;
      cnt_q   <= '0;
      rd_q    <= '0;
      otag_q  <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      rs2_q   <= rs2_d;
      tag_q   <= tag_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      otag_q  <= otag_d;
    end
  end
endmodule

// File: tb/tb_gzip_seq_unit.sv
// tb_gzip_seq_unit: randomized self-checking bench for gzip_seq_unit against a bit-index permutation model.
module tb_gzip_seq_unit;
  logic        clock = 0;
  logic        resetn = 0;
  logic        in_valid = 0;
  logic        in_ready;
  logic [31:0] in_rs1 = 0;
  logic [4:0]  in_rs2 = 0;
  logic [3:0]  in_tag = 0;
  logic        out_valid;
  logic        out_ready = 0;
  logic [31:0] out_rd;
  logic [3:0]  out_tag;
  int n_chk = 0;
  int n_fail = 0;

  gzip_seq_unit #(.TAG_W(4)) dut (
    .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .out_rd(out_rd), .out_tag(out_tag)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Stage N=2^k exchanges bits k and k+1 of every bit index.
  function automatic logic [31:0] perm_stage(input logic [31:0] x, input int k);
    logic [31:0] y;
    for (int j = 0; j < 32; j++) begin
      int a = (j >> k) & 1;
      int b = (j >> (k + 1)) & 1;
      int src = (j & ~(3 << k)) | (a << (k + 1)) | (b << k);
      y[j] = x[src];
    end
    return y;
  endfunction

  function automatic logic [31:0] ref_gzip(input logic [31:0] x, input logic [4:0] c);
    logic [31:0] y = x;
    for (int i = 0; i < 4; i++) begin
      int k = c[0] ? 3 - i : i;
      if (c[k + 1]) y = perm_stage(y, k);
    end
    return y;
  endfunction

  function automatic int exp_lat(input logic [4:0] c);
`ifdef GZIP_SEQ_SKIP_EN
    int n = $countones(c[4:1]);
    return n < 1 ? 1 : n;
`else
    return 4;
`endif
  endfunction

  task automatic do_op(input logic [31:0] rs1, input logic [4:0] rs2, input logic [3:0] tag,
                       input int hold, output logic [31:0] rd);
    int lat = 0;
    @(negedge clock);
    check("in_ready_idle", in_ready, 1);
    in_valid = 1; in_rs1 = rs1; in_rs2 = rs2; in_tag = tag;
    @(posedge clock); #1;
    in_valid = 0; in_rs1 = $urandom; in_rs2 = 5'($urandom); in_tag = 4'($urandom);
    while (!out_valid && lat < 20) begin
      @(posedge clock); #1;
      lat++;
    end
    check("latency", lat, exp_lat(rs2));
    check("rd", out_rd, ref_gzip(rs1, rs2));
    check("tag", out_tag, tag);
    rd = out_rd;
    for (int h = 0; h < hold; h++) begin
      @(negedge clock);
      in_valid = 1'($urandom); in_rs1 = $urandom; in_rs2 = 5'($urandom); in_tag = 4'($urandom);
      @(posedge clock); #1;
      check("hold_valid", out_valid, 1);
      check("hold_ready", in_ready, 0);
      check("hold_rd", out_rd, rd);
      check("hold_tag", out_tag, tag);
    end
    @(negedge clock);
    in_valid = 0; out_ready = 1;
    @(posedge clock); #1;
    out_ready = 0;
    check("post_valid", out_valid, 0);
    check("post_ready", in_ready, 1);
    check("post_rd_held", out_rd, rd);
  endtask

  initial begin
    logic [31:0] r, r2, x;
    logic [3:0]  e;
    repeat (2) @(posedge clock);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_rd", out_rd, 0);
    check("rst_out_tag", out_tag, 0);
    @(negedge clock) resetn = 1;
    do_op(32'h0000ffff, 5'h1f, 4'h3, 0, r);
    check("vec1", r, 32'h55555555);
    do_op(32'h55555555, 5'h1e, 4'h5, 0, r);
    check("vec2", r, 32'h0000ffff);
    do_op(32'h0000ff00, 5'h11, 4'h9, 0, r);
    check("vec3", r, 32'h00ff0000);
    do_op(32'hdeadbeef, 5'h00, 4'h1, 0, r);
    check("vec4a", r, 32'hdeadbeef);
    do_op(32'hdeadbeef, 5'h01, 4'h2, 3, r);
    check("vec4b", r, 32'hdeadbeef);
    // reset in the middle of RUN discards the op
    @(negedge clock);
    in_valid = 1; in_rs1 = 32'h12345678; in_rs2 = 5'h1f; in_tag = 4'hc;
    @(posedge clock); #1;
    in_valid = 0;
    @(posedge clock);
    @(negedge clock) resetn = 0;
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_rd", out_rd, 0);
    check("midrst_tag", out_tag, 0);
    check("midrst_ready", in_ready, 1);
    @(negedge clock) resetn = 1;
    for (int i = 0; i < 1000; i++)
      do_op($urandom, 5'($urandom), 4'($urandom), (i % 50 == 0) ? 3 : int'($urandom_range(0, 1)), r);
    for (int i = 0; i < 50; i++) begin
      x = $urandom;
      e = 4'($urandom);
      do_op(x, {e, 1'b1}, 4'($urandom), 0, r);
      do_op(r, {e, 1'b0}, 4'($urandom), 0, r2);
      check("roundtrip", r2, x);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
